fbuff_row_writer: RTL
=====================

// Module: fbuff_row_writer
// PURPOSE
// - Write side of the frame buffer; the line buffers are the read side.
// - Accepts a stream of tile colours over a valid/ready handshake and packs
//   TILE_PER_ROW tiles into one memory row.
// - Writes each packed row to consecutive frame buffer addresses, 0 to
//   FBUFF_DEPTH-1, so that one pass fills one complete frame.
// - Shares the single frame buffer port with the line buffers. Each row write
//   is requested from an external arbiter and performed only when granted.
// PARAMETERS
// - PXL_WIDTH         12    bits per tile colour (3 x 4-bit RGB)
// - TILE_PER_ROW      5     tiles packed per frame buffer row
// - FBUFF_DEPTH       3840  rows per frame (19200 tiles / 5)
// - FBUFF_ADDR_WIDTH  12    $clog2(FBUFF_DEPTH)
// - FBUFF_DATA_WIDTH  60    TILE_PER_ROW*PXL_WIDTH
// PORTS
// - clk_i         in   1                 system clock; all logic on its rising edge
// - rst_i         in   1                 asynchronous, active-high reset
// - start_i       in   1                 begin a frame write at address 0; ignored unless idle
// - tile_valid_i  in   1                 tile_data_i is valid
// - tile_data_i   in   PXL_WIDTH         tile colour
// - tile_ready_o  out  1                 block can accept a tile this cycle
// - fbuff_req_o   out  1                 a packed row is pending; requests the frame buffer port
// - fbuff_gnt_i   in   1                 arbiter grants the frame buffer port this cycle
// - fbuff_en_o    out  1                 frame buffer enable
// - fbuff_wen_o   out  1                 frame buffer write enable
// - fbuff_addr_o  out  FBUFF_ADDR_WIDTH  row address
// - fbuff_data_o  out  FBUFF_DATA_WIDTH  packed row data
// - busy_o        out  1                 a frame write is in progress
// - frame_done_o  out  1                 one-cycle pulse after the last row is written
// BEHAVIOUR
// - One clock. Reset is asynchronous and active-high.
// - Reset values: all outputs 0. State = IDLE. Address, tile index and row register = 0.
// - FSM states: IDLE, FILL, WRITE, DONE.
// - IDLE:
//   - start_i=1: next state FILL; address cleared to 0; tile index cleared to 0.
//   - tile_valid_i and fbuff_gnt_i are ignored.
// - FILL:
//   - tile_ready_o=1.
//   - On valid&ready, tile_data_i is stored at row[idx*PXL_WIDTH +: PXL_WIDTH] and idx
//     increments. Tile 0 occupies the least significant bits.
//   - When the tile accepted is idx=TILE_PER_ROW-1: idx wraps to 0; next state WRITE.
//   - Gaps in tile_valid_i stall FILL with no effect on stored data.
// - WRITE:
//   - tile_ready_o=0; fbuff_req_o=1.
//   - fbuff_addr_o and fbuff_data_o are registered and stable throughout WRITE.
//   - fbuff_en_o = fbuff_wen_o = fbuff_gnt_i, combinational and gated by state==WRITE.
//     The memory captures the row on the same clock edge.
//   - On a granted cycle with address < FBUFF_DEPTH-1: address increments; next state FILL.
//   - On a granted cycle with address == FBUFF_DEPTH-1: next state DONE.
//   - The grant may be withheld indefinitely; the block holds in WRITE with no write.
// - DONE:
//   - frame_done_o=1 for exactly one cycle; next state IDLE.
//   - The address wraps to 0 on the next start_i.
// - busy_o=1 in FILL, WRITE and DONE.
// - fbuff_gnt_i outside WRITE has no effect: en/wen stay 0.
// - start_i while busy is ignored; the frame in progress is unaffected.
// - Throughput with the grant held high: TILE_PER_ROW+1 cycles per row, i.e. one bubble per row.
// - Reset mid-frame: returns immediately to IDLE. The partial row is discarded and never
//   written, and no frame_done_o pulse is produced.
// TESTING
// - Reset check: assert rst_i mid-cycle -> every output 0 immediately and
//   tile_ready_o=0, before the next clock edge.
// - Single row: start_i, then tiles 0x111,0x222,0x333,0x444,0x555 back-to-back with
//   gnt=1 -> exactly one write at addr 0 with data 0x555444333222111, and
//   tile_ready_o low for 1 cycle.
// - Grant stall: hold gnt=0 for 10 cycles in WRITE -> req=1, ready=0, en/wen=0,
//   and addr/data stable; raise gnt -> exactly one write, then FILL at addr 1.
// - Full frame: 19200 tiles with tile r*5+t = {3{r[3:0]}} -> 3840 writes to addr 0..3839 in
//   order; frame_done_o pulses once, one cycle after addr 3839 is written; readback via
//   line buffers matches.
// - Ignored inputs: start_i during FILL/WRITE, tile_valid_i in IDLE, and
//   gnt in IDLE/FILL -> no state change and no writes.
// - Reset after 3 tiles of row 7 -> no write to addr 7; the next start_i plus 5 tiles
//   writes addr 0.

Source files
------------

// File: rtl/fbuff_row_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fbuff_row_writer
// Brief    : Packs a stream of tile colours into frame buffer rows and writes
//            one full frame of rows through an arbitrated memory port.
// Revision : 1.0 - initial release
// ============================================================================
module fbuff_row_writer #(
  parameter int PXL_WIDTH        = 12,
  parameter int TILE_PER_ROW     = 5,
  parameter int FBUFF_DEPTH      = 3840,
  parameter int FBUFF_ADDR_WIDTH = 12,
  parameter int FBUFF_DATA_WIDTH = 60
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        tile_valid_i,
  input  logic [PXL_WIDTH-1:0]        tile_data_i,
  output logic                        tile_ready_o,
  output logic                        fbuff_req_o,
  input  logic                        fbuff_gnt_i,
  output logic                        fbuff_en_o,
  output logic                        fbuff_wen_o,
  output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
  output logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_o,
  output logic                        busy_o,
  output logic                        frame_done_o
);

  localparam int IDX_W = (TILE_PER_ROW > 1) ? $clog2(TILE_PER_ROW) : 1;
  localparam logic [IDX_W-1:0]            C_LAST_IDX  = IDX_W'(TILE_PER_ROW - 1);
  localparam logic [FBUFF_ADDR_WIDTH-1:0] C_LAST_ADDR = FBUFF_ADDR_WIDTH'(FBUFF_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [IDX_W-1:0]              r_idx;
  logic [FBUFF_ADDR_WIDTH-1:0]   r_addr;
  logic [FBUFF_DATA_WIDTH-1:0]   r_row;

  logic w_start;
  logic w_accept;
  logic w_write;
  logic w_last_tile;
  logic w_last_row;

  assign w_start     = (r_state == S_IDLE) && start_i;
  assign w_accept    = (r_state == S_FILL) && tile_valid_i;
  assign w_write     = (r_state == S_WRITE) && fbuff_gnt_i;
  assign w_last_tile = (r_idx == C_LAST_IDX);
  assign w_last_row  = (r_addr == C_LAST_ADDR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    tile_ready_o = 1'b0;
    fbuff_req_o  = 1'b0;
    fbuff_en_o   = 1'b0;
    fbuff_wen_o  = 1'b0;
    busy_o       = 1'b1;
    frame_done_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_next = S_FILL;
      end
      S_FILL: begin
        tile_ready_o = 1'b1;
        if (tile_valid_i && w_last_tile) w_next = S_WRITE;
      end
      S_WRITE: begin
        // The memory samples en/wen on the same edge that advances the FSM.
        fbuff_req_o = 1'b1;
        fbuff_en_o  = fbuff_gnt_i;
        fbuff_wen_o = fbuff_gnt_i;
        if (fbuff_gnt_i) w_next = w_last_row ? S_DONE : S_FILL;
      end
      S_DONE: begin
        frame_done_o = 1'b1;
        w_next       = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx  <= '0;
      r_addr <= '0;
      r_row  <= '0;
    end else begin
      if (w_start) begin
        r_idx  <= '0;
        r_addr <= '0;
      end
      if (w_accept) begin
        for (int t = 0; t < TILE_PER_ROW; t++) begin
          if (r_idx == IDX_W'(t)) r_row[t*PXL_WIDTH +: PXL_WIDTH] <= tile_data_i;
        end
        r_idx <= w_last_tile ? '0 : r_idx + 1'b1;
      end
      if (w_write && !w_last_row) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign fbuff_addr_o = r_addr;
  assign fbuff_data_o = r_row;

endmodule
`default_nettype wire
